// File: rtl/common_types_pkg.sv
// Shared types for the memory stage: load/store opcodes, fault codes and
// the alignment rule used to reject misaligned half/word accesses.
package common_types_pkg;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LH  = 4'd1,
    LSU_LW  = 4'd2,
    LSU_LBU = 4'd3,
    LSU_LHU = 4'd4,
    LSU_SB  = 4'd5,
    LSU_SH  = 4'd6,
    LSU_SW  = 4'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } lsu_fault_t;

  function automatic logic is_store(lsu_op_t op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  // Only the two low address bits matter for alignment.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] offset);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return offset[0];
      LSU_LW, LSU_SW:          return offset != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and lane-replicated write data, plus
// selection and sign/zero extension of load data from the 32-bit bus word.
module lsu_align
  import common_types_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_data[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    strb  = 4'b0000;
    wdata = 32'h0;
    rdata = 32'h0;
    case (op)
      LSU_SB: begin
        strb  = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      LSU_SH: begin
        strb  = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      LSU_SW: begin
        strb  = 4'hF;
        wdata = store_data;
      end
      LSU_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: rdata = {24'h0, byte_sel};
      LSU_LH:  rdata = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: rdata = {16'h0, half_sel};
      LSU_LW:  rdata = load_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one op from EX, runs a single bus
// transfer with valid/ready handshake, then pulses a formatted result or fault.
module load_store_unit
  import common_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output lsu_fault_t  resp_fault,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;

  lsu_state_t  state, next_state;
  lsu_op_t     op_q;
  logic [31:0] addr_q, wdata_q, rdata_q, wait_cnt;
  lsu_fault_t  fault_q;
  logic        squash_q;

  logic        accept, misaligned, timeout_hit, in_bus, store_q;
  logic [3:0]  fmt_strb;
  logic [31:0] fmt_wdata, fmt_rdata;

  assign accept      = (state == IDLE) && req_valid && !flush;
  assign misaligned  = is_misaligned(req_op, req_addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !dmem_ready &&
                       (wait_cnt == TIMEOUT_CYCLES - 1);
  assign in_bus      = (state == BUS);
  assign store_q     = is_store(op_q);

  lsu_align u_align (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .store_data (wdata_q),
    .load_data  (dmem_rdata),
    .strb       (fmt_strb),
    .wdata      (fmt_wdata),
    .rdata      (fmt_rdata)
  );

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = misaligned ? RESP : BUS;
      BUS:     if (dmem_ready || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: these are plain flops, not a memory, so clearing them on reset is cheap
  // and keeps stale data off the response bus.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q     <= LSU_LB;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      wait_cnt <= 32'h0;
      fault_q  <= FAULT_NONE;
      squash_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= req_op;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          rdata_q  <= 32'h0;
          wait_cnt <= 32'h0;
          squash_q <= 1'b0;
          fault_q  <= misaligned ? FAULT_MISALIGN : FAULT_NONE;
        end
        BUS: begin
          wait_cnt <= wait_cnt + 32'd1;
          // A flush here cannot abort the transfer; only its response is dropped.
          if (flush) squash_q <= 1'b1;
          if (dmem_ready)       rdata_q <= fmt_rdata;
          else if (timeout_hit) fault_q <= FAULT_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    dmem_ren   = in_bus && !store_q;
    dmem_wen   = in_bus && store_q;
    dmem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    dmem_wdata = dmem_wen ? fmt_wdata : 32'h0;
    dmem_strb  = dmem_wen ? fmt_strb : 4'b0000;
    resp_valid = (state == RESP) && !squash_q && !flush;
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_fault = resp_valid ? fault_q : FAULT_NONE;
  end

endmodule
